// File: rtl/mips_debug_frame_writer.sv
// Debug request responder: decodes a one-cycle select, snapshots or reads the chosen source,
// and streams it as NB_REG-bit frames (MSB word first) followed by a one-cycle end-of-data pulse.
module mips_debug_frame_writer #(
    parameter int unsigned NB_REG        = 32,
    parameter int unsigned NB_ADDR_DATA  = 16,
    parameter int unsigned NB_INSTR_ADDR = 9,
    parameter int unsigned NB_LATCH      = 96
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [5:0]                i_request_select,
    input  logic [NB_ADDR_DATA-1:0]   i_addr,
    output logic [4:0]                o_reg_addr,
    input  logic [NB_REG-1:0]         i_reg_data,
    output logic [NB_ADDR_DATA-1:0]   o_data_mem_addr,
    output logic                      o_data_mem_re,
    input  logic [NB_REG-1:0]         i_data_mem_data,
    output logic [NB_INSTR_ADDR-1:0]  o_instr_mem_addr,
    output logic                      o_instr_mem_re,
    input  logic [NB_REG-1:0]         i_instr_mem_data,
    input  logic [NB_REG-1:0]         i_pc,
    input  logic [8*NB_LATCH-1:0]     i_latches,
    output logic [NB_REG-1:0]         o_frame,
    output logic                      o_eod,
    output logic                      o_busy
);

    localparam int unsigned WORDS  = NB_LATCH / NB_REG;
    localparam int unsigned NB_CNT = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [5:0] SEL_NONE  = 6'h3F;
    localparam logic [5:0] SEL_DMEM  = 6'h20;
    localparam logic [5:0] SEL_IMEM  = 6'h21;
    localparam logic [5:0] SEL_PC    = 6'h22;
    localparam logic [5:0] SEL_LATCH = 6'h24;
    localparam logic [5:0] SEL_LAST  = 6'h2B;

    typedef enum logic [1:0] {StIdle, StSendMem, StSendLatch, StEod} state_t;

    state_t                r_state, w_state;
    logic [NB_LATCH-1:0]   r_shift, w_shift;
    logic [NB_CNT-1:0]     r_cnt, w_cnt;
    logic [5:0]            r_sel, w_sel;
    logic [2:0]            w_group;
    logic [NB_LATCH-1:0]   w_strip;

    assign o_reg_addr       = i_request_select[4:0];
    assign o_data_mem_addr  = i_addr;
    assign o_instr_mem_addr = i_addr[NB_INSTR_ADDR-1:0];
    assign o_data_mem_re    = (r_state == StIdle) && (i_request_select == SEL_DMEM);
    assign o_instr_mem_re   = (r_state == StIdle) && (i_request_select == SEL_IMEM);
    assign o_eod            = (r_state == StEod);
    assign o_busy           = (r_state != StIdle);

    assign w_group = 3'(i_request_select - SEL_LATCH);

    always_comb begin
        w_strip = '0;
        for (int k = 0; k < 8; k++) begin
            if (w_group == 3'(k)) w_strip = i_latches[k*NB_LATCH +: NB_LATCH];
        end
    end

    always_comb begin
        w_state = r_state;
        w_shift = r_shift;
        w_cnt   = r_cnt;
        w_sel   = r_sel;
        o_frame = '0;
        case (r_state)
            StIdle: begin
                if (i_request_select != SEL_NONE) begin
                    w_sel = i_request_select;
                    if (!i_request_select[5] || i_request_select == SEL_DMEM ||
                        i_request_select == SEL_IMEM) begin
                        w_state = StSendMem;
                    end else if (i_request_select == SEL_PC) begin
                        w_shift = {i_pc, {(NB_LATCH-NB_REG){1'b0}}};
                        w_cnt   = '0;
                        w_state = StSendLatch;
                    end else if (i_request_select >= SEL_LATCH &&
                                 i_request_select <= SEL_LAST) begin
                        w_shift = w_strip;
                        w_cnt   = NB_CNT'(WORDS - 1);
                        w_state = StSendLatch;
                    end else begin
                        w_state = StEod;
                    end
                end
            end
            StSendMem: begin
                // Read data arrives one cycle after the strobe; pick it by the latched select.
                if (!r_sel[5])              o_frame = i_reg_data;
                else if (r_sel == SEL_DMEM) o_frame = i_data_mem_data;
                else                        o_frame = i_instr_mem_data;
                w_state = StEod;
            end
            StSendLatch: begin
                o_frame = r_shift[NB_LATCH-1 -: NB_REG];
                w_shift = r_shift << NB_REG;
                if (r_cnt == '0) w_state = StEod;
                else             w_cnt   = r_cnt - NB_CNT'(1);
            end
            StEod: begin
                w_state = StIdle;
            end
            default: begin
                w_state = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_shift <= '0;
            r_cnt   <= '0;
            r_sel   <= SEL_NONE;
        end else begin
            r_state <= w_state;
            r_shift <= w_shift;
            r_cnt   <= w_cnt;
            r_sel   <= w_sel;
        end
    end

endmodule
